// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the staged reset sequencer.
package rst_seq_pkg;

  localparam int MAX_OUTS = 16;

  typedef enum logic [1:0] {
    SYNC,
    STRETCH,
    RELEASE,
    RUN
  } state_e;

  // One spare bit so a count of the largest interval never wraps.
  function automatic int calcCntW(input int stretchCycles, input int numOuts,
                                  input int stageGap, input int wdogCycles);
    int maxVal;
    maxVal = stretchCycles;
    if ((numOuts - 1) * stageGap > maxVal) maxVal = (numOuts - 1) * stageGap;
    if (wdogCycles > maxVal) maxVal = wdogCycles;
    return $clog2(maxVal) + 1;
  endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Reset synchronizer: asserts asynchronously, releases after SYNC_STAGES edges.
module rst_sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic sync_rst_o,
  output logic sync_rst_next_o
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain_q <= '1;
    else     chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b0};
  end

  // The value the final stage loads on the coming edge, so the caller can
  // act on the same edge the synchronized reset falls.
  assign sync_rst_o      = chain_q[SYNC_STAGES-1];
  assign sync_rst_next_o = chain_q[SYNC_STAGES-2];

endmodule

// File: rtl/rst_seq_gen.sv
// Staged reset generator: async assert, stretch, then in-order synchronous release.
// Optional watchdog enabled by defining RSTSEQ_WDOG_EN.
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 16,
  parameter int NUM_OUTS       = 4,
  parameter int STAGE_GAP      = 4,
  parameter int WDOG_CYCLES    = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sw_rst_req,
`ifdef RSTSEQ_WDOG_EN
  input  logic                wdog_kick,
  output logic                wdog_fired,
`endif
  output logic [NUM_OUTS-1:0] rst_out,
  output logic                busy,
  output logic                done
);

  localparam int CNT_W = calcCntW(STRETCH_CYCLES, NUM_OUTS, STAGE_GAP, WDOG_CYCLES);
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'((NUM_OUTS - 1) * STAGE_GAP - 1);
`ifdef RSTSEQ_WDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LAST    = CNT_W'(WDOG_CYCLES - 1);
`endif

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [NUM_OUTS-1:0] rst_out_q, rst_out_d;
  logic                done_q, done_d;
  logic                fire_q, fire_d;
  logic                sync_rst, sync_rst_next;

  rst_sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk            (clk),
    .rst            (rst),
    .sync_rst_o     (sync_rst),
    .sync_rst_next_o(sync_rst_next)
  );

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_out_d = rst_out_q;
    done_d    = 1'b0;
    fire_d    = 1'b0;
    case (state_q)
      SYNC: begin
        if (sync_rst && !sync_rst_next) begin
          state_d = STRETCH;
          cnt_d   = '0;
        end
      end
      STRETCH: begin
        if (cnt_q == STRETCH_LAST) begin
          rst_out_d[0] = 1'b0;
          cnt_d        = '0;
          if (NUM_OUTS == 1) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RELEASE: begin
        // Single counter measured from the bit-0 release; bit k drops at k*STAGE_GAP.
        cnt_d = cnt_inc;
        for (int k = 1; k < NUM_OUTS; k++) begin
          if (int'(cnt_inc) >= k * STAGE_GAP) rst_out_d[k] = 1'b0;
        end
        if (cnt_q == RELEASE_LAST) begin
          state_d = RUN;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      RUN: begin
`ifdef RSTSEQ_WDOG_EN
        if (wdog_kick)               cnt_d  = '0;
        else if (cnt_q == WDOG_LAST) fire_d = 1'b1;
        else                         cnt_d  = cnt_inc;
`endif
      end
      default: state_d = SYNC;
    endcase
    // A software or watchdog restart skips the synchronizer: it is already in-domain.
    if ((state_q != SYNC) && (sw_rst_req || fire_d)) begin
      rst_out_d = '1;
      cnt_d     = '0;
      state_d   = STRETCH;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SYNC;
      cnt_q     <= '0;
      rst_out_q <= '1;
      done_q    <= 1'b0;
      fire_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
      fire_q    <= fire_d;
    end
  end

  assign rst_out = rst_out_q;
  assign busy    = |rst_out_q;
  assign done    = done_q;
`ifdef RSTSEQ_WDOG_EN
  assign wdog_fired = fire_q;
`else
  logic unusedFire;
  assign unusedFire = fire_q;
`endif

endmodule

// File: doc/rst_seq_gen.md
Name: rst_seq_gen

Overview:
- Generates the staged, glitch-free reset outputs that the team's async-reset flops consume.
- Takes a raw asynchronous reset plus an optional software reset request.
- Asserts all reset outputs asynchronously and stretches them for a fixed time, then releases them synchronously, one output at a time, in index order.
- Sits at the top of each clock domain, between the board/PLL reset and the datapath blocks.

Parameters:
SYNC_STAGES, 2, flops in deassertion synchronizer (legal >=2)
STRETCH_CYCLES, 16, clk cycles all outputs held after synchronized release (>=1)
NUM_OUTS, 4, number of staged reset outputs (1..16)
STAGE_GAP, 4, clk cycles between successive output releases (>=1)
WDOG_CYCLES, 1024, watchdog timeout; used only with optional feature

Ports:
clk  input  1  domain clock
rst  input  1  raw reset, asynchronous, active-high
sw_rst_req  input  1  synchronous software reset request, sampled each rising clk edge
rst_out  output  NUM_OUTS  staged resets, active-high; rst_out[0] released first
busy  output  1  high while any rst_out bit is high
done  output  1  one-cycle pulse on the edge the last output releases
wdog_kick  input  1  present only with RSTSEQ_WDOG_EN
wdog_fired  output  1  present only with RSTSEQ_WDOG_EN

Behaviour:
- Interface (decided): reset rst, asynchronous, active-high; clock clk.
- rst high:
  - all rst_out=1 and busy=1 immediately, with no clk needed.
  - done=0, sync chain all 1, FSM=SYNC, counters=0.
- States: SYNC, STRETCH, RELEASE, RUN.
- SYNC:
  - The synchronizer shifts 0 in per edge after rst falls.
  - The synchronized reset goes low at edge SYNC_STAGES, where edge 1 is the first rising edge after rst deasserts.
  - The FSM enters STRETCH on that edge.
- STRETCH:
  - The counter increments each edge.
  - rst_out[0] releases at edge SYNC_STAGES+STRETCH_CYCLES.
  - The FSM enters RELEASE on that edge, or RUN when NUM_OUTS=1.
- RELEASE:
  - rst_out[k] releases at edge SYNC_STAGES+STRETCH_CYCLES+k*STAGE_GAP.
  - Lower indices stay released.
- Last release edge:
  - rst_out=0, busy=0 and done=1 for exactly one cycle.
  - The FSM enters RUN.
- RUN: outputs hold 0 and done=0.
- sw_rst_req sampled high at edge E in STRETCH, RELEASE or RUN:
  - all rst_out=1 and busy=1 after E, with the counter cleared.
  - rst_out[0] releases at E+STRETCH_CYCLES.
  - rst_out[k] releases at E+STRETCH_CYCLES+k*STAGE_GAP.
  - The synchronizer is bypassed because the request is already synchronous.
- sw_rst_req in SYNC: ignored.
- sw_rst_req held high: the schedule restarts every cycle and outputs stay asserted.
- rst asserted mid-STRETCH or mid-RELEASE: immediate full re-assertion. The schedule restarts from SYNC.
- Outputs change only on clk edges, except the asynchronous assertion. No combinational path from any input to rst_out.
- Counter width: clog2 of the largest of STRETCH_CYCLES, (NUM_OUTS-1)*STAGE_GAP and WDOG_CYCLES, plus 1. No wrap within a schedule.

Optional Feature:
- Macro: RSTSEQ_WDOG_EN.
- Defined:
  - The wdog_kick and wdog_fired ports exist.
  - A watchdog counter runs only in RUN and clears on wdog_kick=1 or on leaving RUN.
  - If WDOG_CYCLES consecutive RUN cycles pass without a kick, the block acts as sw_rst_req on that edge and wdog_fired pulses for 1 cycle.
  - A kick on the terminal cycle wins: no fire.
  - wdog_fired resets to 0.
- Undefined: ports absent, no counter logic. Behaviour otherwise identical.

Decomposition:
- Package rst_seq_pkg:
  - state enum (SYNC, STRETCH, RELEASE, RUN).
  - localparam CNT_W function/derivation.
  - MAX_OUTS=16.
- Sub-module rst_sync_chain:
  - parameterised SYNC_STAGES flop chain.
  - asynchronous assert, synchronous deassert, output reset value 1.
  - instantiated once.

Test Plan (defaults unless stated):
- rst high 3 cycles then low: rst_out=4'hF until edge 18. Bit0 releases at 18, bit1 at 22, bit2 at 26, bit3 at 30. done=1 only in the cycle after edge 30. busy falls at 30.
- rst pulsed between clk edges while in RUN: rst_out=4'hF within the same cycle with no edge, then the full 18/22/26/30 schedule repeats.
- sw_rst_req=1 for one cycle at edge E in RUN: rst_out=4'hF after E. Releases at E+16, E+20, E+24, E+28. One done pulse.
- sw_rst_req at edge 24 during RELEASE (bits 0,1 already low): all bits reassert, then release at 40/44/48/52. done fires only once.
- NUM_OUTS=1, STRETCH_CYCLES=1: rst_out releases at edge 3, with done on the same edge.
- RSTSEQ_WDOG_EN, WDOG_CYCLES=8:
  - no kicks → wdog_fired pulse and reset after 8 RUN cycles.
  - a kick every 7 cycles → never fires.
